// File: rtl/out_display_pkg.sv
// -----------------------------------------------------------------------------
// out_display_pkg
//   Shared definitions for the output-register display path:
//     - state_t      : converter FSM states (IDLE / CONV / LOAD)
//     - SEG_*        : 7-segment codes, bit order gfedcba, active-low
//                      (common-anode display, a 0 lights the segment)
//     - seg7_decode  : BCD nibble -> segment code, non-decimal nibbles blank
// -----------------------------------------------------------------------------
package out_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/out_display_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
//   Iterative double-dabble converter, one binary bit per clock.
//   A start pulse seen in IDLE captures bin and clears the accumulator; WIDTH
//   CONV cycles follow, then one LOAD cycle during which done is high and bcd
//   holds the finished result.
// Parameters
//   WIDTH : width of the binary operand
//   NDIG  : number of BCD nibbles in the accumulator
// Ports
//   clk   in   1          clock, posedge
//   rst   in   1          asynchronous active-high reset
//   start in   1          request a conversion (acted on only in IDLE)
//   bin   in   WIDTH      unsigned value to convert
//   busy  out  1          high whenever the FSM is not in IDLE
//   done  out  1          high for the single LOAD cycle
//   bcd   out  NDIG*4     BCD accumulator (final only while done is high)
// -----------------------------------------------------------------------------
module bin_to_bcd #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  bin,
    output logic              busy,
    output logic              done,
    output logic [NDIG*4-1:0] bcd
);
    import out_display_pkg::*;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [NDIG*4-1:0]   acc_q, acc_d;
    logic [NDIG*4-1:0]   adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each CONV cycle first corrects every nibble that would overflow past 9
    // once doubled, then shifts the whole {bcd, bin} pair left by one.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        adj     = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (adj[i*4 +: 4] >= 4'd5) begin
                        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
                    end
                end
                {acc_d, bin_d} = {adj[NDIG*4-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == LOAD);
    assign bcd  = acc_q;

endmodule

// File: rtl/out_display.sv
// -----------------------------------------------------------------------------
// out_display
//   Display end of the output register. Watches i_data, converts each new
//   value to BCD through bin_to_bcd and shows the result on a time-multiplexed
//   active-low common-anode 7-segment display. Digit 0 is least significant.
// Parameters
//   WIDTH    : width of i_data
//   DIGITS   : number of display digits
//   SCAN_DIV : mclk cycles each digit stays lit (>= 2)
// Ports
//   mclk   in   1       system clock, posedge
//   rst    in   1       asynchronous active-high reset
//   i_data in   WIDTH   binary value from the output register
//   o_seg  out  7       segments gfedcba, active-low, registered
//   o_an   out  DIGITS  digit enables, active-low one-hot, registered
//   o_busy out  1       high while a conversion is in flight
// Configuration
//   OUT_DISPLAY_SIGNED_EN : when defined, i_data is two's complement; the top
//   digit shows a minus sign (or blank) and the rest show |i_data|.
// -----------------------------------------------------------------------------
module out_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  i_data,
    output logic [6:0]        o_seg,
    output logic [DIGITS-1:0] o_an,
    output logic              o_busy
);
    import out_display_pkg::*;

`ifdef OUT_DISPLAY_SIGNED_EN
    localparam int NUM_BCD = DIGITS - 1;
`else
    localparam int NUM_BCD = DIGITS;
`endif
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [WIDTH-1:0]     last_val_q, last_val_d;
    logic [NUM_BCD*4-1:0] disp_bcd_q, disp_bcd_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]     dig_idx_q,  dig_idx_d;
    logic [6:0]           seg_q,      seg_d;
    logic [DIGITS-1:0]    an_q,       an_d;
    logic                 scan_wrap;
    logic                 conv_start;
    logic                 conv_busy;
    logic                 conv_done;
    logic [WIDTH-1:0]     conv_bin;
    logic [NUM_BCD*4-1:0] conv_bcd;
`ifdef OUT_DISPLAY_SIGNED_EN
    logic                 cap_neg_q,  cap_neg_d;
    logic                 disp_neg_q, disp_neg_d;
`endif

    // A new conversion is only requested while the converter is idle, so a
    // value that changes mid-conversion is picked up by the next idle compare.
    assign conv_start = !conv_busy && (i_data != last_val_q);

`ifdef OUT_DISPLAY_SIGNED_EN
    // Magnitude is kept WIDTH bits unsigned so the most negative value is exact.
    assign conv_bin = i_data[WIDTH-1] ? (~i_data + 1'b1) : i_data;
`else
    assign conv_bin = i_data;
`endif

    bin_to_bcd #(
        .WIDTH (WIDTH),
        .NDIG  (NUM_BCD)
    ) u_bin_to_bcd (
        .clk   (mclk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            last_val_q <= '0;
            disp_bcd_q <= '0;
            scan_cnt_q <= '0;
            dig_idx_q  <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
`ifdef OUT_DISPLAY_SIGNED_EN
            cap_neg_q  <= 1'b0;
            disp_neg_q <= 1'b0;
`endif
        end else begin
            last_val_q <= last_val_d;
            disp_bcd_q <= disp_bcd_d;
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
`ifdef OUT_DISPLAY_SIGNED_EN
            cap_neg_q  <= cap_neg_d;
            disp_neg_q <= disp_neg_d;
`endif
        end
    end

    // The sign is held beside the conversion and only joins the displayed
    // value when the matching BCD result is loaded.
    always_comb begin
        last_val_d = conv_start ? i_data   : last_val_q;
        disp_bcd_d = conv_done  ? conv_bcd : disp_bcd_q;
`ifdef OUT_DISPLAY_SIGNED_EN
        cap_neg_d  = conv_start ? i_data[WIDTH-1] : cap_neg_q;
        disp_neg_d = conv_done  ? cap_neg_q       : disp_neg_q;
`endif
    end

    // Free-running scanner; the outputs are registered from the current digit
    // index, so each digit stays lit for exactly SCAN_DIV cycles.
    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        dig_idx_d  = dig_idx_q;
        if (scan_wrap) begin
            dig_idx_d = (dig_idx_q == IDX_W'(DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
        end
        an_d  = ~(DIGITS'(1) << dig_idx_q);
        seg_d = seg7_decode(4'(disp_bcd_q >> {dig_idx_q, 2'b00}));
`ifdef OUT_DISPLAY_SIGNED_EN
        if (dig_idx_q == IDX_W'(DIGITS - 1)) begin
            seg_d = disp_neg_q ? SEG_MINUS : SEG_BLANK;
        end
`endif
    end

    assign o_seg  = seg_q;
    assign o_an   = an_q;
    assign o_busy = conv_busy;

endmodule
